grid_move_resolver: RTL and testbench

//  Registered, parametrised player-movement resolver. Holds the player position, accepts
//  one move per valid/ready handshake, checks the target tile against one of NUM_MAPS

---
 rtl/grid_move_resolver_if.sv | 49 ++++
 rtl/grid_move_resolver.sv | 169 ++++++++++++++++
 tb/tb_grid_move_resolver.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_move_resolver_if.sv
// Bundle of request/result signals between input decode, level loader and the resolver.
// Latency: none (wires only).
// Backpressure: move channel uses move_valid/move_ready, result channel res_valid/res_ready.
interface grid_move_resolver_if #(
  parameter int GRID_W  = 20,
  parameter int COORD_W = 5,
  parameter int MAP_W   = 2,
  parameter int CNT_W   = 8
);
  // spawn request
  logic               spawn_valid;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  // move request channel
  logic               move_valid;
  logic               move_ready;
  logic [2:0]         move;
  logic [MAP_W-1:0]   map_sel;
  // wall map row write port
  logic               map_wr_en;
  logic [MAP_W-1:0]   map_wr_sel;
  logic [COORD_W-1:0] map_wr_row;
  logic [GRID_W-1:0]  map_wr_data;
  // committed state and result channel
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               res_valid;
  logic               res_ready;
  logic               res_blocked;
  logic [CNT_W-1:0]   blocked_cnt;

  modport master (
    output spawn_valid, spawn_x, spawn_y,
    output move_valid, move, map_sel,
    input  move_ready,
    output map_wr_en, map_wr_sel, map_wr_row, map_wr_data,
    input  pos_x, pos_y, res_valid, res_blocked, blocked_cnt,
    output res_ready
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y,
    input  move_valid, move, map_sel,
    output move_ready,
    input  map_wr_en, map_wr_sel, map_wr_row, map_wr_data,
    output pos_x, pos_y, res_valid, res_blocked, blocked_cnt,
    input  res_ready
  );
endinterface

// File: rtl/grid_move_resolver.sv
// Player movement resolver: checks a one-tile move against a selectable wall bitmap and commits or blocks it.
// Latency: result valid 3 cycles after move accept; next move accepted the cycle after the result handshake.
// Backpressure: move_ready low outside IDLE or while spawning; result held in RESP until res_ready.
module grid_move_resolver #(
  parameter int GRID_W   = 20,
  parameter int GRID_H   = 15,
  parameter int COORD_W  = 5,
  parameter int NUM_MAPS = 4,
  parameter int MAP_W    = 2,
  parameter int CNT_W    = 8
) (
  input logic                 clk,
  input logic                 resetn,
  grid_move_resolver_if.slave bus
);

  localparam int COL_AW = (GRID_W   > 1) ? $clog2(GRID_W)   : 1;
  localparam int ROW_AW = (GRID_H   > 1) ? $clog2(GRID_H)   : 1;
  localparam int MAP_AW = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;

  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [MAP_W:0]     MAP_CNT  = (MAP_W + 1)'(NUM_MAPS);
  localparam logic [GRID_W-1:0]  EDGE_ROW = {1'b1, {(GRID_W - 2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_RESOLVE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t state, state_nx;

  // wall bitmaps: bit [x] of row [y] set means wall
  logic [GRID_W-1:0] map_mem [NUM_MAPS][GRID_H];

  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic [COORD_W-1:0] tx_q, ty_q;
  logic [MAP_W-1:0]   sel_q;
  logic               oob_q, none_q;
  logic [GRID_W-1:0]  row_buf;
  logic               res_blocked_q;
  logic [CNT_W-1:0]   blocked_cnt_q;

  logic [COORD_W-1:0] tgt_x, tgt_y;
  logic               tgt_oob, tgt_none;
  logic               move_ready_c, res_valid_c;
  logic               accept, spawn_ok, wr_ok, sel_ok, blocked;

  assign accept   = bus.move_valid && move_ready_c;
  assign spawn_ok = (state == S_IDLE) && bus.spawn_valid &&
                    (bus.spawn_x <= X_MAX) && (bus.spawn_y <= Y_MAX);
  assign wr_ok    = bus.map_wr_en && ({1'b0, bus.map_wr_sel} < MAP_CNT) &&
                    (bus.map_wr_row <= Y_MAX);
  assign sel_ok   = ({1'b0, sel_q} < MAP_CNT);
  // a "none" move stays put and is never rejected, even if standing on a wall
  assign blocked  = !none_q && (oob_q || row_buf[COL_AW'(tx_q)]);

  // target tile from current position and move code; edges flag oob instead of wrapping
  always_comb begin
    tgt_x    = pos_x_q;
    tgt_y    = pos_y_q;
    tgt_oob  = 1'b0;
    tgt_none = 1'b0;
    case (bus.move)
      3'b100: if (pos_x_q == X_MAX) tgt_oob = 1'b1; else tgt_x = pos_x_q + ONE;
      3'b001: if (pos_y_q == '0)    tgt_oob = 1'b1; else tgt_y = pos_y_q - ONE;
      3'b010: if (pos_x_q == '0)    tgt_oob = 1'b1; else tgt_x = pos_x_q - ONE;
      3'b011: if (pos_y_q == Y_MAX) tgt_oob = 1'b1; else tgt_y = pos_y_q + ONE;
      default: tgt_none = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx     = state;
    move_ready_c = 1'b0;
    res_valid_c  = 1'b0;
    case (state)
      S_IDLE: begin
        move_ready_c = !bus.spawn_valid;
        if (bus.move_valid && !bus.spawn_valid) state_nx = S_LOOKUP;
      end
      S_LOOKUP:  state_nx = S_RESOLVE;
      S_RESOLVE: state_nx = S_RESP;
      S_RESP: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // wall map storage: border pattern on reset, row writes from the level loader in any state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int m = 0; m < NUM_MAPS; m++) begin
        for (int r = 0; r < GRID_H; r++) begin
          map_mem[m][r] <= (r == 0 || r == GRID_H - 1) ? {GRID_W{1'b1}} : EDGE_ROW;
        end
      end
    end else if (wr_ok) begin
      map_mem[MAP_AW'(bus.map_wr_sel)][ROW_AW'(bus.map_wr_row)] <= bus.map_wr_data;
    end
  end

  // capture the accepted move: target, map select and flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_q   <= '0;
      ty_q   <= '0;
      sel_q  <= '0;
      oob_q  <= 1'b0;
      none_q <= 1'b0;
    end else if (accept) begin
      tx_q   <= tgt_x;
      ty_q   <= tgt_y;
      sel_q  <= bus.map_sel;
      oob_q  <= tgt_oob;
      none_q <= tgt_none;
    end
  end

  // registered row read; a same-cycle write lands after this sample, so the old row is seen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_buf <= '0;
    end else if (state == S_LOOKUP) begin
      row_buf <= sel_ok ? map_mem[MAP_AW'(sel_q)][ROW_AW'(ty_q)] : {GRID_W{1'b1}};
    end
  end

  // position, result flag and saturating blocked counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x_q       <= ONE;
      pos_y_q       <= ONE;
      res_blocked_q <= 1'b0;
      blocked_cnt_q <= '0;
    end else if (spawn_ok) begin
      pos_x_q <= bus.spawn_x;
      pos_y_q <= bus.spawn_y;
    end else if (state == S_RESOLVE) begin
      res_blocked_q <= blocked;
      if (blocked) begin
        if (blocked_cnt_q != {CNT_W{1'b1}}) blocked_cnt_q <= blocked_cnt_q + CNT_W'(1);
      end else begin
        pos_x_q <= tx_q;
        pos_y_q <= ty_q;
      end
    end
  end

  assign bus.move_ready  = move_ready_c;
  assign bus.res_valid   = res_valid_c;
  assign bus.res_blocked = res_blocked_q;
  assign bus.pos_x       = pos_x_q;
  assign bus.pos_y       = pos_y_q;
  assign bus.blocked_cnt = blocked_cnt_q;

endmodule

// File: tb/tb_grid_move_resolver.sv
// Self-checking bench for grid_move_resolver: directed table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: bench holds res_ready low for varying cycles while offering extra moves.
module tb_grid_move_resolver;

  localparam int GW = 20;
  localparam int GH = 15;
  localparam int NM = 3;   // fewer maps than map_sel can address, so select 3 is out of range

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  grid_move_resolver_if #(.GRID_W(GW), .COORD_W(5), .MAP_W(2), .CNT_W(8)) bus ();

  grid_move_resolver #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(5), .NUM_MAPS(NM), .MAP_W(2), .CNT_W(8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int nerr = 0;
  int nchk = 0;

  // behavioural model state
  logic [GW-1:0] mdl_map [4][GH];
  int mdl_x, mdl_y, mdl_cnt;

  // write-during-lookup hook used by do_move
  bit            wl_en  = 0;
  logic [1:0]    wl_sel;
  logic [4:0]    wl_row;
  logic [GW-1:0] wl_dat;

  typedef struct {
    int         sx, sy;
    logic [2:0] mv;
    int         sel;
    bit         blk;
    int         ex, ey;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [GW-1:0] border_row(input int r);
    logic [GW-1:0] v;
    if (r == 0 || r == GH - 1) v = '1;
    else begin
      v = '0;
      v[0] = 1'b1;
      v[GW-1] = 1'b1;
    end
    return v;
  endfunction

  task automatic mdl_reset();
    for (int m = 0; m < 4; m++)
      for (int r = 0; r < GH; r++) mdl_map[m][r] = border_row(r);
    mdl_x = 1; mdl_y = 1; mdl_cnt = 0;
  endtask

  // move rule from the tile grid: step one tile, reject outside the grid, on a wall, or bad map
  task automatic mdl_move(input int mv, input int sel, output bit blk);
    int dx, dy, nx, ny;
    dx = 0; dy = 0;
    case (mv)
      4: dx = 1;
      1: dy = -1;
      2: dx = -1;
      3: dy = 1;
      default: ;
    endcase
    nx = mdl_x + dx;
    ny = mdl_y + dy;
    if (dx == 0 && dy == 0) blk = 0;
    else if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) blk = 1;
    else if (sel >= NM) blk = 1;
    else blk = mdl_map[sel][ny][nx];
    if (blk) mdl_cnt = (mdl_cnt < 255) ? mdl_cnt + 1 : 255;
    else begin mdl_x = nx; mdl_y = ny; end
  endtask

  task automatic spawn(input int x, input int y);
    @(negedge clk);
    bus.spawn_valid = 1'b1;
    bus.spawn_x = 5'(x);
    bus.spawn_y = 5'(y);
    #1 chk("ready_low_on_spawn", bus.move_ready, 0);
    @(negedge clk);
    bus.spawn_valid = 1'b0;
  endtask

  task automatic map_write(input int sel, input int row, input logic [GW-1:0] dat);
    @(negedge clk);
    bus.map_wr_en = 1'b1;
    bus.map_wr_sel = 2'(sel);
    bus.map_wr_row = 5'(row);
    bus.map_wr_data = dat;
    @(negedge clk);
    bus.map_wr_en = 1'b0;
  endtask

  task automatic do_move(input logic [2:0] mv, input int sel, input bit eblk,
                         input int ex, input int ey, input int ecnt, input int hold);
    int lat;
    @(negedge clk);
    chk("move_ready_idle", bus.move_ready, 1);
    bus.move_valid = 1'b1;
    bus.move = mv;
    bus.map_sel = 2'(sel);
    @(negedge clk);
    bus.move_valid = 1'b0;
    lat = 1;
    if (wl_en) begin
      bus.map_wr_en = 1'b1;
      bus.map_wr_sel = wl_sel;
      bus.map_wr_row = wl_row;
      bus.map_wr_data = wl_dat;
    end
    while (!bus.res_valid && lat < 8) begin
      @(negedge clk);
      bus.map_wr_en = 1'b0;
      lat++;
    end
    bus.map_wr_en = 1'b0;
    chk("latency", lat, 3);
    chk("res_blocked", bus.res_blocked, int'(eblk));
    chk("pos_x", bus.pos_x, ex);
    chk("pos_y", bus.pos_y, ey);
    chk("blocked_cnt", bus.blocked_cnt, ecnt);
    if (hold > 0) begin
      bus.move_valid = 1'b1;
      bus.move = 3'b100;
      bus.map_sel = 2'd0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_res_valid", bus.res_valid, 1);
        chk("hold_res_blocked", bus.res_blocked, int'(eblk));
        chk("hold_move_ready", bus.move_ready, 0);
      end
    end
    bus.res_ready = 1'b1;
    bus.move_valid = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("post_res_valid", bus.res_valid, 0);
    chk("post_move_ready", bus.move_ready, 1);
    chk("post_pos_x", bus.pos_x, ex);
    chk("post_pos_y", bus.pos_y, ey);
  endtask

  initial begin
    int  ecnt, cyc_hi;
    bit  b;
    logic [GW-1:0] row;

    tbl[0]  = '{1, 1, 3'b100, 0, 0, 2, 1};
    tbl[1]  = '{1, 1, 3'b010, 0, 1, 1, 1};
    tbl[2]  = '{1, 1, 3'b001, 0, 1, 1, 1};
    tbl[3]  = '{0, 0, 3'b001, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 3'b010, 0, 1, 0, 0};
    tbl[5]  = '{19, 14, 3'b100, 0, 1, 19, 14};
    tbl[6]  = '{19, 14, 3'b011, 0, 1, 19, 14};
    tbl[7]  = '{18, 13, 3'b100, 0, 1, 18, 13};
    tbl[8]  = '{5, 5, 3'b011, 0, 0, 5, 6};
    tbl[9]  = '{5, 5, 3'b000, 0, 0, 5, 5};
    tbl[10] = '{0, 0, 3'b111, 0, 0, 0, 0};
    tbl[11] = '{5, 5, 3'b100, 3, 1, 5, 5};
    tbl[12] = '{5, 5, 3'b101, 3, 0, 5, 5};
    tbl[13] = '{18, 13, 3'b011, 1, 1, 18, 13};
    tbl[14] = '{2, 2, 3'b001, 2, 0, 2, 1};

    bus.spawn_valid = 0; bus.spawn_x = 0; bus.spawn_y = 0;
    bus.move_valid = 0; bus.move = 0; bus.map_sel = 0;
    bus.map_wr_en = 0; bus.map_wr_sel = 0; bus.map_wr_row = 0; bus.map_wr_data = 0;
    bus.res_ready = 0;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_pos_x", bus.pos_x, 1);
    chk("rst_pos_y", bus.pos_y, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_blocked", bus.res_blocked, 0);
    chk("rst_cnt", bus.blocked_cnt, 0);
    chk("rst_move_ready", bus.move_ready, 1);

    // first move straight out of reset
    do_move(3'b100, 0, 0, 2, 1, 0, 0);

    // directed table against border maps
    ecnt = 0;
    for (int i = 0; i < 15; i++) begin
      spawn(tbl[i].sx, tbl[i].sy);
      chk("spawn_x", bus.pos_x, tbl[i].sx);
      chk("spawn_y", bus.pos_y, tbl[i].sy);
      if (tbl[i].blk) ecnt++;
      do_move(tbl[i].mv, tbl[i].sel, tbl[i].blk, tbl[i].ex, tbl[i].ey, ecnt, i % 3);
    end

    // out-of-range spawns are ignored
    spawn(5, 5);
    spawn(20, 3);
    chk("oor_spawn_x", bus.pos_x, 5);
    spawn(3, 15);
    chk("oor_spawn_y", bus.pos_y, 5);

    // wall written into map 2 only
    row = border_row(5);
    row[6] = 1'b1;
    map_write(2, 5, row);
    ecnt++;
    do_move(3'b100, 2, 1, 5, 5, ecnt, 0);
    do_move(3'b100, 0, 0, 6, 5, ecnt, 5);

    // write to the row being looked up: lookup sees the old row, next move sees the new one
    spawn(5, 5);
    wl_en = 1; wl_sel = 2'd1; wl_row = 5'd5; wl_dat = row;
    do_move(3'b100, 1, 0, 6, 5, ecnt, 0);
    wl_en = 0;
    spawn(5, 5);
    ecnt++;
    do_move(3'b100, 1, 1, 5, 5, ecnt, 0);

    // saturation of the blocked counter
    spawn(0, 0);
    for (int i = 0; i < 300; i++) begin
      ecnt = (ecnt < 255) ? ecnt + 1 : 255;
      do_move(3'b001, 0, 1, 0, 0, ecnt, 0);
    end
    chk("cnt_saturated", bus.blocked_cnt, 255);

    // reset while a move is in LOOKUP
    spawn(3, 3);
    @(negedge clk);
    bus.move_valid = 1'b1; bus.move = 3'b100; bus.map_sel = 2'd0;
    @(negedge clk);
    bus.move_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_pos_x", bus.pos_x, 1);
    chk("mid_rst_pos_y", bus.pos_y, 1);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_res_blocked", bus.res_blocked, 0);
    chk("mid_rst_cnt", bus.blocked_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc_hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.res_valid) cyc_hi++;
    end
    chk("mid_rst_no_result", cyc_hi, 0);
    chk("mid_rst_pos_kept", bus.pos_x, 1);
    // map 2 is back to the plain border: (6,5) reachable again
    spawn(5, 5);
    do_move(3'b100, 2, 0, 6, 5, 0, 0);

    // random traffic against the tile model
    mdl_reset();
    mdl_x = 6; mdl_y = 5;
    for (int i = 0; i < 250; i++) begin
      int op, s, r, x, y, mv, h;
      op = $urandom_range(0, 9);
      if (op < 2) begin
        s = $urandom_range(0, 3);
        r = $urandom_range(0, GH - 1);
        row = GW'($urandom & $urandom & $urandom);
        map_write(s, r, row);
        if (s < NM) mdl_map[s][r] = row;
      end else if (op < 4) begin
        x = $urandom_range(0, GW + 3);
        y = $urandom_range(0, GH + 2);
        spawn(x, y);
        if (x < GW && y < GH) begin mdl_x = x; mdl_y = y; end
        chk("rnd_spawn_x", bus.pos_x, mdl_x);
        chk("rnd_spawn_y", bus.pos_y, mdl_y);
      end else begin
        mv = $urandom_range(0, 7);
        s  = $urandom_range(0, 3);
        h  = $urandom_range(0, 2);
        mdl_move(mv, s, b);
        do_move(3'(mv), s, b, mdl_x, mdl_y, mdl_cnt, h);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
